// File: rtl/alu_operand_serializer_pkg.sv
// Shared widths, derived beat-count constants and FSM state type for the
// ALU operand serializer.
package alu_operand_serializer_pkg;

  localparam int OPERAND_BUS_WIDTH      = 8;
  localparam int OPERAND_MAX_DATA_WIDTH = 32;
  localparam int OP_WIDTH               = 4;
  localparam int MAX_BEATS              = OPERAND_MAX_DATA_WIDTH / OPERAND_BUS_WIDTH;
  localparam int CNT_W                  = $clog2(MAX_BEATS) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  // Zero or oversized beat counts mean "send the full operand width".
  function automatic logic [CNT_W-1:0] norm_beats(input logic [CNT_W-1:0] beats);
    if (beats == '0 || beats > CNT_W'(MAX_BEATS)) return CNT_W'(MAX_BEATS);
    return beats;
  endfunction

endpackage

// File: rtl/alu_operand_serializer.sv
// Slices one full-width ALU request into LSB-first operand beats under
// valid/ready backpressure, with bubble-free back-to-back bursts.
module alu_operand_serializer
  import alu_operand_serializer_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [OP_WIDTH-1:0]           req_op,
  input  logic [OPERAND_MAX_DATA_WIDTH-1:0] req_a,
  input  logic [OPERAND_MAX_DATA_WIDTH-1:0] req_b,
  input  logic [CNT_W-1:0]              req_beats,
  output logic                          operand_valid,
  output logic [OP_WIDTH-1:0]           op,
  output logic [OPERAND_BUS_WIDTH-1:0]  a,
  output logic [OPERAND_BUS_WIDTH-1:0]  b,
  output logic                          operand_last,
  input  logic                          ready,
  output logic                          busy
);

  ser_state_e                          r_state;
  ser_state_e                          w_state_nxt;
  logic [OP_WIDTH-1:0]                 r_op;
  logic [OPERAND_MAX_DATA_WIDTH-1:0]   r_sh_a;
  logic [OPERAND_MAX_DATA_WIDTH-1:0]   r_sh_b;
  logic [CNT_W-1:0]                    r_remaining;

  logic w_sending;
  logic w_last;
  logic w_beat_hs;
  logic w_accept;

  assign w_sending = (r_state == SEND);
  assign w_last    = w_sending && (r_remaining == CNT_W'(1));
  assign w_beat_hs = w_sending && ready;

  // A new request may land on the final beat's handshake, keeping SEND busy.
  assign req_ready = !rst && ((r_state == IDLE) || (w_last && ready));
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SEND;
      SEND:    if (w_beat_hs && w_last && !w_accept) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_sh_a      <= '0;
      r_sh_b      <= '0;
      r_remaining <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op        <= req_op;
        r_sh_a      <= req_a;
        r_sh_b      <= req_b;
        r_remaining <= norm_beats(req_beats);
      end else if (w_beat_hs) begin
        r_sh_a      <= r_sh_a >> OPERAND_BUS_WIDTH;
        r_sh_b      <= r_sh_b >> OPERAND_BUS_WIDTH;
        r_remaining <= r_remaining - CNT_W'(1);
      end
    end
  end

  assign operand_valid = w_sending;
  assign busy          = w_sending;
  assign operand_last  = w_last;
  assign op            = r_op;
  assign a             = r_sh_a[OPERAND_BUS_WIDTH-1:0];
  assign b             = r_sh_b[OPERAND_BUS_WIDTH-1:0];

endmodule

// File: doc/alu_operand_serializer.md
# alu_operand_serializer

Initiator for the multi-cycle ALU operand bus. It accepts one full-width request (op, A, B, beat count) over a valid/ready handshake. It then slices A and B into OPERAND_BUS_WIDTH beats, least-significant first, and drives them onto operand_valid/op/a/b/operand_last under the ALU's ready backpressure. It sits between a stimulus or host source and the operand port of alu_multi_cycle.

## Interface
- OPERAND_BUS_WIDTH, 8, width of one operand beat
- OPERAND_MAX_DATA_WIDTH, 32, full operand width; must be a multiple of OPERAND_BUS_WIDTH
- OP_WIDTH, 4, opcode width
- MAX_BEATS (derived), OPERAND_MAX_DATA_WIDTH/OPERAND_BUS_WIDTH
- CNT_W (derived), $clog2(MAX_BEATS)+1
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_op  in  OP_WIDTH  opcode for the whole burst
- req_a  in  OPERAND_MAX_DATA_WIDTH  operand A
- req_b  in  OPERAND_MAX_DATA_WIDTH  operand B
- req_beats  in  CNT_W  beats to send
- operand_valid  out  1  beat valid
- op  out  OP_WIDTH  opcode, constant for all beats of a burst
- a  out  OPERAND_BUS_WIDTH  A slice
- b  out  OPERAND_BUS_WIDTH  B slice
- operand_last  out  1  final beat of the burst
- ready  in  1  ALU accepts a beat when operand_valid && ready
- busy  out  1  burst in progress, equal to operand_valid

## Operation
- FSM with two states, IDLE and SEND.
- Beat count is normalized at accept: req_beats == 0 or req_beats > MAX_BEATS → MAX_BEATS; otherwise req_beats.
- **IDLE:** req_ready=1, operand_valid=0. On accept, the block latches op, A and B into shift registers, loads remaining = normalized count, and moves to SEND.
- **SEND:** operand_valid=1; a/b = low OPERAND_BUS_WIDTH bits of the shift registers; operand_last = (remaining == 1).
- On a beat handshake:
  - The shift registers shift right by OPERAND_BUS_WIDTH, and remaining decrements.
  - If the handshaken beat was the last one, the block returns to IDLE, unless a new request is accepted in the same cycle.
- **Back-to-back:** req_ready = IDLE || (SEND && operand_last && ready). This is combinational from state and ready. A request accepted on the last-beat handshake reloads the registers and the block stays in SEND, so there is no bubble.
- **Stall:** while operand_valid && !ready, all outputs (op, a, b, operand_last) hold stable. operand_valid never drops mid-burst.
- Upper bits beyond the requested beat count are never driven out.

## Timing
- **Reset values:** operand_valid=0, operand_last=0, op=0, a=0, b=0, busy=0, state=IDLE. req_ready=0 while rst is high.
- **Reset mid-burst:** the burst is abandoned and no operand_last is issued. Outputs take reset values from the cycle after the rst edge.
- **Latency:** a request accepted at edge N → first beat valid in cycle N+1.
- A burst of k beats with ready held high occupies exactly k cycles.
- Throughput: one beat per cycle, with no idle cycle between bursts when req_valid is presented during the last beat.
- **Simultaneous rst and req_valid:** reset wins and the request is not accepted.

## Structure
- **Shared package:** OPERAND_BUS_WIDTH, OPERAND_MAX_DATA_WIDTH, OP_WIDTH, the derived MAX_BEATS/CNT_W, and a `ser_state_e` enum {IDLE, SEND}.
- Single module, no sub-modules. The beat counter and shift registers are inline, at roughly 150 lines.

## Test plan
- **Basic burst:** req_a=0x12345678, req_b=0x9ABCDEF0, req_op=2, req_beats=4, ready=1 → a=78,56,34,12 and b=F0,DE,BC,9A on consecutive cycles. op=2 on all beats, operand_last only on the 4th beat, first beat one cycle after accept.
- **Backpressure:** same request with ready=0 for 3 cycles at beat 2 → a=56 and b=DE held stable for 4 cycles; the total sequence is unchanged with no duplicated or skipped beats.
- **Beat count edges:**
  - req_beats=1 → single beat with operand_last=1, a=78.
  - req_beats=0 → 4 beats.
  - req_beats=7 → 4 beats.
- **Back-to-back:** second request (A=0xAABBCCDD, beats=2) held valid during the first burst → accepted in the last-beat cycle. a=DD,CC follows immediately with no gap, and op switches to the new opcode.
- **Reset mid-burst:** rst=1 during beat 3 → operand_valid=0 and req_ready=0 next cycle. After rst drops, req_ready=1, and a new request starts cleanly from its beat 0.
